// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared definitions for the write-bus arbiter and its writers
// Contents: FSM state encoding, writer id width helper, and the busy/request
// levels that every writer instance and the arbiter must agree on.
package arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Width of a writer index; never narrower than one bit so a single-writer
  // build still has a legal id field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Busy high means "hands off the bus"; busy low means "drive it now".
  localparam logic BUSY_HOLD = 1'b1;
  localparam logic BUSY_GO   = 1'b0;
  // Request level a writer holds while it wants (and keeps) the bus.
  localparam logic REQ_ON    = 1'b1;

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - writer bus plus output word stream of the arbiter
// Signals: i_req/o_busy per-writer handshake, i_bus shared data bus,
// o_data/o_id/o_valid/i_ready downstream word slot.
// Modports: master = arbiter side, slave = writers + consumer side.
interface bus_arbiter_if
  import arb_pkg::*;
#(
  parameter int NUM_WRITERS = 2,
  parameter int DATA_WIDTH  = 8
) ();

  localparam int ID_W = id_width(NUM_WRITERS);

  logic [NUM_WRITERS-1:0] i_req;
  logic [NUM_WRITERS-1:0] o_busy;
  logic [DATA_WIDTH-1:0]  i_bus;
  logic [DATA_WIDTH-1:0]  o_data;
  logic [ID_W-1:0]        o_id;
  logic                   o_valid;
  logic                   i_ready;

  modport master (
    input  i_req, i_bus, i_ready,
    output o_busy, o_data, o_id, o_valid
  );

  modport slave (
    output i_req, i_bus, i_ready,
    input  o_busy, o_data, o_id, o_valid
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner selection
// Ports: req (request vector), last (previous winner) -> any (some request
// set), winner (first set request scanning upward cyclically from last+1).
module rr_pick
  import arb_pkg::*;
#(
  parameter int N    = 2,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic            any,
  output logic [ID_W-1:0] winner
);

  int idx;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    // Offsets 1..N so the previous winner is considered last.
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter for a shared tri-state write bus
// Ports: i_clk, i_reset_n (async active-low), bus (bus_arbiter_if.master):
// i_req/o_busy writer handshake, i_bus sampled in the grant cycle,
// o_data/o_id/o_valid/i_ready registered output word slot.
module bus_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_WRITERS = 2,
  parameter int DATA_WIDTH  = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  bus_arbiter_if.master bus
);

  localparam int ID_W = id_width(NUM_WRITERS);

  arb_state_e             state_q;
  logic [NUM_WRITERS-1:0] busy_q;
  logic [ID_W-1:0]        win_q;
  logic [ID_W-1:0]        last_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [ID_W-1:0]        id_q;
  logic                   valid_q;

  logic                   pick_any;
  logic [ID_W-1:0]        pick_w;
  logic                   slot_free;

  rr_pick #(.N(NUM_WRITERS), .ID_W(ID_W)) u_pick (
    .req    (bus.i_req),
    .last   (last_q),
    .any    (pick_any),
    .winner (pick_w)
  );

  // A grant is only issued when the captured word will have somewhere to go.
  assign slot_free = !valid_q || bus.i_ready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      busy_q  <= {NUM_WRITERS{BUSY_HOLD}};
      win_q   <= '0;
      last_q  <= ID_W'(NUM_WRITERS - 1);
      data_q  <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      // Acceptance clears the slot; a capture below on the same edge wins.
      if (valid_q && bus.i_ready) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (pick_any && slot_free) begin
            win_q          <= pick_w;
            busy_q         <= {NUM_WRITERS{BUSY_HOLD}};
            busy_q[pick_w] <= BUSY_GO;
            state_q        <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Pointer moves even if the writer dropped its request early.
          busy_q  <= {NUM_WRITERS{BUSY_HOLD}};
          last_q  <= win_q;
          state_q <= ST_IDLE;
          if (bus.i_req[win_q] == REQ_ON) begin
            data_q  <= bus.i_bus;
            id_q    <= win_q;
            valid_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_busy  = busy_q;
  assign bus.o_data  = data_q;
  assign bus.o_id    = id_q;
  assign bus.o_valid = valid_q;

endmodule
